// File: rtl/mem_reg_arbiter_if.sv
// rtl/mem_reg_arbiter_if.sv - requester and register-bank signal bundle for mem_reg_arbiter
interface mem_reg_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        ack0;
  logic        ack1;
  logic        err;
  logic [15:0] rdata;
  logic        mem_reg_read;
  logic        mem_reg_write;
  logic [15:0] read_address;
  logic [15:0] write_address;
  logic [15:0] write_data;
  logic [15:0] bank_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bank_rdata,
    output gnt0, gnt1, ack0, ack1, err, rdata,
    output mem_reg_read, mem_reg_write, read_address, write_address, write_data
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bank_rdata,
    input  gnt0, gnt1, ack0, ack1, err, rdata,
    input  mem_reg_read, mem_reg_write, read_address, write_address, write_data
  );
endinterface

// File: rtl/mem_reg_arbiter.sv
// rtl/mem_reg_arbiter.sv - two-requester round-robin arbiter onto a memory-register bank
// Defining MEM_REG_ARB_FIXED_PRIO_EN makes requester 0 always win ties.
module mem_reg_arbiter #(
  parameter logic [15:0] BASE_ADDR = 16'd32,
  parameter logic [15:0] TOP_ADDR  = 16'd63
) (
  input  logic             clk,
  input  logic             reset,
  mem_reg_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        owner;
  logic        we_q;
  logic        err_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;

  logic        any_req;
  logic        sel;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_bad;
  logic        take;

  assign any_req = bus.req0 | bus.req1;
  assign take    = (state == IDLE) && any_req;

`ifdef MEM_REG_ARB_FIXED_PRIO_EN
  always_comb begin
    sel = ~bus.req0;
  end
`else
  // last = requester granted most recently; reset value 1 makes requester 0 preferred
  logic last;

  always_comb begin
    sel = bus.req1;
    if (bus.req0 && bus.req1) begin
      sel = ~last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (take) begin
      last <= sel;
    end
  end
`endif

  assign sel_we    = sel ? bus.we1    : bus.we0;
  assign sel_addr  = sel ? bus.addr1  : bus.addr0;
  assign sel_wdata = sel ? bus.wdata1 : bus.wdata0;
  assign sel_bad   = (sel_addr < BASE_ADDR) || (sel_addr > TOP_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = sel_bad ? RESP : ACCESS;
      ACCESS:  state_nxt = we_q ? RESP : CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction context is frozen at the grant so a dropped req cannot disturb it
  always_ff @(posedge clk) begin
    if (reset) begin
      owner   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
    end else begin
      if (take) begin
        owner   <= sel;
        we_q    <= sel_we;
        err_q   <= sel_bad;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state == CAPTURE) begin
        rdata_q <= bus.bank_rdata;
      end
    end
  end

  always_comb begin
    bus.gnt0          = 1'b0;
    bus.gnt1          = 1'b0;
    bus.ack0          = 1'b0;
    bus.ack1          = 1'b0;
    bus.err           = 1'b0;
    bus.mem_reg_read  = 1'b0;
    bus.mem_reg_write = 1'b0;
    if (state != IDLE) begin
      bus.gnt0 = ~owner;
      bus.gnt1 = owner;
    end
    if (state == ACCESS) begin
      bus.mem_reg_read  = ~we_q;
      bus.mem_reg_write = we_q;
    end
    if (state == RESP) begin
      bus.ack0 = ~owner;
      bus.ack1 = owner;
      bus.err  = err_q;
    end
  end

  assign bus.rdata         = rdata_q;
  assign bus.read_address  = addr_q;
  assign bus.write_address = addr_q;
  assign bus.write_data    = wdata_q;

endmodule

// File: tb/tb_mem_reg_arbiter.sv
// tb/tb_mem_reg_arbiter.sv - scoreboard bench for mem_reg_arbiter
module tb_mem_reg_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_reg_arbiter_if bus();

  mem_reg_arbiter #(.BASE_ADDR(16'd32), .TOP_ADDR(16'd63)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [15:0] bank [0:255];
  always @(posedge clk) begin
    if (reset) bus.bank_rdata <= 16'd0;
    else if (bus.mem_reg_read) bus.bank_rdata <= bank[bus.read_address[7:0]];
    if (bus.mem_reg_write) bank[bus.write_address[7:0]] <= bus.write_data;
  end

  typedef struct {
    bit          who;
    bit          err;
    bit          is_read;
    int          lat;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] shadow [0:255];
  logic [15:0] rdata_model;
  bit          last_model;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(bit who, bit v, bit we, logic [15:0] a, logic [15:0] d);
    if (!who) begin
      bus.req0 = v; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = v; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic push_exp(bit who, bit we, logic [15:0] a, logic [15:0] d);
    exp_t e;
    e.who     = who;
    e.err     = (a < 16'd32) || (a > 16'd63);
    e.is_read = !we;
    e.addr    = a;
    e.wdata   = d;
    e.lat     = e.err ? 1 : (we ? 2 : 3);
    if (!e.err && we) shadow[a[7:0]] = d;
    if (!e.err && !we) rdata_model = shadow[a[7:0]];
    e.rdata   = rdata_model;
    last_model = who;
    sb.push_back(e);
  endtask

  function automatic bit predict_winner();
`ifdef MEM_REG_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return last_model ? 1'b0 : 1'b1;
`endif
  endfunction

  task automatic check_ack(exp_t e, int cyc);
    check("latency", 32'(cyc), 32'(e.lat));
    check("ack_owner", 32'({bus.ack1, bus.ack0}), e.who ? 32'd2 : 32'd1);
    check("gnt_owner", 32'({bus.gnt1, bus.gnt0}), e.who ? 32'd2 : 32'd1);
    check("err", 32'(bus.err), 32'(e.err));
    check("rdata", 32'(bus.rdata), 32'(e.rdata));
  endtask

  task automatic txn(bit who, bit we, logic [15:0] a, logic [15:0] d, bit drop_early);
    exp_t e;
    int cyc = 0, nrd = 0, nwr = 0, both = 0;
    bit got = 0;
    logic [15:0] s_addr = 16'd0, s_data = 16'd0;
    @(posedge clk); #1;
    set_req(who, 1'b1, we, a, d);
    push_exp(who, we, a, d);
    @(posedge clk);
    if (drop_early) begin
      #1 set_req(who, 1'b0, we, a, d);
    end
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_reg_read) begin nrd++; s_addr = bus.read_address; end
      if (bus.mem_reg_write) begin nwr++; s_addr = bus.write_address; s_data = bus.write_data; end
      if (bus.mem_reg_read && bus.mem_reg_write) both++;
      if (bus.ack0 || bus.ack1) got = 1;
    end
    e = sb.pop_front();
    check("ack_seen", 32'(got), 32'd1);
    if (got) check_ack(e, cyc);
    check("read_strobes", 32'(nrd), (!e.err && e.is_read) ? 32'd1 : 32'd0);
    check("write_strobes", 32'(nwr), (!e.err && !e.is_read) ? 32'd1 : 32'd0);
    check("strobe_overlap", 32'(both), 32'd0);
    if (nrd + nwr > 0) check("strobe_addr", 32'(s_addr), 32'(e.addr));
    if (nwr > 0) check("strobe_wdata", 32'(s_data), 32'(e.wdata));
    set_req(who, 1'b0, we, a, d);
    @(negedge clk);
    check("ack_one_cycle", 32'({bus.ack1, bus.ack0}), 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ctl"}, 32'({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err,
                              bus.mem_reg_read, bus.mem_reg_write}), 32'd0);
    check({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
    check({tag, "_bus"}, {bus.read_address, bus.write_address} | {16'd0, bus.write_data}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int cyc;
    bit got;
    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    set_req(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    last_model  = 1'b1;
    rdata_model = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 reset = 1'b0;

    txn(1'b0, 1'b1, 16'd40, 16'h1234, 1'b0);
    txn(1'b1, 1'b0, 16'd40, 16'h0000, 1'b0);
    txn(1'b1, 1'b1, 16'd32, 16'hA5A5, 1'b0);
    txn(1'b0, 1'b0, 16'd32, 16'h0000, 1'b0);
    txn(1'b0, 1'b1, 16'd63, 16'hBEEF, 1'b0);
    txn(1'b1, 1'b0, 16'd63, 16'h0000, 1'b0);
    txn(1'b1, 1'b0, 16'd31, 16'h0000, 1'b0);
    txn(1'b1, 1'b1, 16'd64, 16'h5555, 1'b0);
    txn(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0);

    // Both requesters hold req across acks; the grant order comes from the model
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b1, 16'd50, 16'h0A0A);
    set_req(1'b1, 1'b1, 1'b1, 16'd51, 16'h0B0B);
    for (int k = 0; k < 4; k++) begin
      if (predict_winner()) push_exp(1'b1, 1'b1, 16'd51, 16'h0B0B);
      else push_exp(1'b0, 1'b1, 16'd50, 16'h0A0A);
      cyc = 0;
      got = 0;
      while (!got && cyc < 10) begin
        @(negedge clk);
        cyc++;
        if (bus.ack0 || bus.ack1) got = 1;
      end
      e = sb.pop_front();
      check("rr_ack_seen", 32'(got), 32'd1);
      check("rr_owner", 32'({bus.ack1, bus.ack0}), e.who ? 32'd2 : 32'd1);
      if (k == 3) begin
        set_req(1'b0, 1'b0, 1'b1, 16'd50, 16'h0A0A);
        set_req(1'b1, 1'b0, 1'b1, 16'd51, 16'h0B0B);
      end
    end
    @(negedge clk);

    txn(1'b0, 1'b1, 16'd45, 16'hC0DE, 1'b1);
    txn(1'b1, 1'b0, 16'd45, 16'h0000, 1'b1);

    // Reset lands while a read sits in CAPTURE
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 16'd40, 16'h0000);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 16'd40, 16'h0000);
    @(negedge clk);
    check("capture_no_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    last_model  = 1'b1;
    rdata_model = 16'd0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(negedge clk);
    check("post_reset_no_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
    txn(1'b1, 1'b0, 16'd40, 16'h0000, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_reg_arbiter.md
MEM_REG_ARBITER -- requirements
Module: mem_reg_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32: lowest legal memory-register address.
REQ-002 SHALL have parameter TOP_ADDR, default 63: highest legal memory-register address.
REQ-003 SHALL have port clk  input  1  single system clock, all state on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1 each  access request from requester 0/1, held until ack.
REQ-006 SHALL have ports we0/we1  input  1 each  1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1  input  16 each  target address.
REQ-008 SHALL have ports wdata0/wdata1  input  16 each  write data.
REQ-009 SHALL have ports gnt0/gnt1  output  1 each  requester owns bank (ACCESS through RESP).
REQ-010 SHALL have ports ack0/ack1  output  1 each  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  valid with ack: address out of range, no bank access made.
REQ-012 SHALL have port rdata  output  16  read result, valid with ack on reads, held until the next read completes.
REQ-013 SHALL have ports mem_reg_read, mem_reg_write  output  1 each  bank strobes.
REQ-014 SHALL have ports read_address, write_address, write_data  output  16 each  bank address/data.
REQ-015 SHALL have port bank_rdata  input  16  bank read data, valid one cycle after mem_reg_read.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, CAPTURE, RESP.
REQ-017 IDLE: on an edge with any req high, SHALL latch owner, we, addr, wdata of the selected requester; in range -> ACCESS, out of range (addr < BASE_ADDR or addr > TOP_ADDR, unsigned) -> RESP with err set.
REQ-018 Selection SHALL be round-robin: single request wins; both requesting -> the requester not served last; after reset, requester 0 is preferred.
REQ-019 ACCESS: SHALL assert exactly one strobe (mem_reg_read if read, mem_reg_write if write) for exactly one cycle with latched address/data; read -> CAPTURE, write -> RESP.
REQ-020 CAPTURE: SHALL register bank_rdata into rdata, then -> RESP.
REQ-021 RESP: SHALL assert ack of the owner for exactly one cycle, then -> IDLE; err SHALL be low in RESP except on range error.
REQ-022 Latency from the request-sampling edge: write ack in cycle 2, read ack in cycle 3, error ack in cycle 1.
REQ-023 Requests SHALL NOT be sampled outside IDLE; a req dropped mid-transaction SHALL NOT abort it (transaction completes, ack still pulses).
REQ-024 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-025 Strobes SHALL never be asserted simultaneously; address/data outputs SHALL be stable while a strobe is high.
REQ-026 The served-last bit SHALL update only on a grant, including range-error grants.

Reset
REQ-027 On reset high at a clock edge, state SHALL go to IDLE regardless of current state; the in-flight transaction SHALL be dropped without ack.
REQ-028 Reset values: gnt0=gnt1=ack0=ack1=err=0, mem_reg_read=mem_reg_write=0, rdata=0, address/data outputs=0, served-last selects requester 0 next.

Configuration
REQ-029 With macro MEM_REG_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (requester 0 always wins ties) and the served-last register SHALL be absent.
REQ-030 Without MEM_REG_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-018.

Verification
REQ-031 req0=1, we0=1, addr0=40, wdata0=0x1234 -> one-cycle mem_reg_write with write_address=40, write_data=0x1234; ack0 in cycle 2; err=0.
REQ-032 After REQ-031, req1=1, we1=0, addr1=40, bank returns 0x1234 -> one-cycle mem_reg_read with read_address=40; ack1 in cycle 3 with rdata=0x1234.
REQ-033 req0 and req1 both held high continuously, both writes -> grants alternate 0,1,0,1 (fixed-prio build: 0,0,0,...).
REQ-034 req1=1, addr1=31, then addr1=64 -> ack1 with err=1 in cycle 1, no strobe asserted in either case.
REQ-035 Read in flight, reset pulsed during CAPTURE -> no ack, all outputs at reset values next cycle; subsequent request served normally.
